// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
package debounce_pkg;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    WAIT1  = 3'd1,
    ONE    = 3'd2,
    REPEAT = 3'd3,
    WAIT0  = 3'd4
  } db_state_t;

  // Counter width wide enough for the largest of the three timing windows.
  function automatic int unsigned clog2max(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, stability counter, five-state FSM
// and registered level / press / release / auto-repeat outputs.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES    = 2_000_000,
  parameter int unsigned REPEAT_DELAY = 40_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter logic        REPEAT_EN    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy,
  output logic debounced,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = clog2max(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [1:0]       sync_q;
  logic             sync;
  db_state_t        state_q;
  db_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_clr_c;
  logic             rpt_c;

  assign sync = sync_q[1];

  // State, counter, synchroniser and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= 2'b00;
      state_q       <= ZERO;
      cnt_q         <= '0;
      debounced     <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], noisy};
      state_q       <= state_d;
      cnt_q         <= cnt_clr_c ? '0 : cnt_q + CNT_W'(1);
      debounced     <= (state_d == ONE) || (state_d == REPEAT) || (state_d == WAIT0);
      press         <= (state_q == WAIT1) && (state_d == ONE);
      release_pulse <= (state_q == WAIT0) && (state_d == ZERO);
      repeat_pulse  <= rpt_c;
    end
  end

  // Next-state decode; any state change also restarts the counter.
  always_comb begin
    state_d = state_q;
    rpt_c   = 1'b0;
    unique case (state_q)
      ZERO: begin
        if (sync) state_d = WAIT1;
      end
      WAIT1: begin
        if (!sync)                state_d = ZERO;
        else if (cnt_q == DB_LAST) state_d = ONE;
      end
      ONE: begin
        if (!sync) begin
          state_d = WAIT0;
        end else if (REPEAT_EN && (cnt_q == DELAY_LAST)) begin
          state_d = REPEAT;
          rpt_c   = 1'b1;
        end
      end
      REPEAT: begin
        if (!sync)                   state_d = WAIT0;
        else if (cnt_q == RATE_LAST) rpt_c   = 1'b1;
      end
      WAIT0: begin
        if (sync)                  state_d = ONE;
        else if (cnt_q == DB_LAST) state_d = ZERO;
      end
      default: state_d = ZERO;
    endcase
    cnt_clr_c = (state_d != state_q) || rpt_c;
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel button debouncer: independent debounce_channel per input pin.
module debounce_multi #(
  parameter int unsigned     N_CH         = 5,
  parameter int unsigned     DB_CYCLES    = 2_000_000,
  parameter int unsigned     REPEAT_DELAY = 40_000_000,
  parameter int unsigned     REPEAT_RATE  = 10_000_000,
  parameter logic [N_CH-1:0] REPEAT_EN    = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_EN   (REPEAT_EN[i])
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .noisy        (noisy[i]),
      .debounced    (debounced[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with an event scoreboard checked every cycle.
module tb_debounce_multi;

  localparam int unsigned N_CH = 2;
  localparam int unsigned DB   = 8;
  localparam int unsigned RD   = 20;
  localparam int unsigned RR   = 5;
  localparam logic [N_CH-1:0] REN = 2'b10;
  localparam int unsigned LAT  = DB + 3;  // drive cycle -> first cycle output visible

  localparam int unsigned K_PRESS = 0;
  localparam int unsigned K_REL   = 1;
  localparam int unsigned K_RPT   = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N_CH-1:0] noisy;
  logic [N_CH-1:0] debounced;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;

  debounce_multi #(
    .N_CH        (N_CH),
    .DB_CYCLES   (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .REPEAT_EN   (REN)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .noisy        (noisy),
    .debounced    (debounced),
    .press        (press),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int unsigned ch;
    int unsigned kind;
  } ev_t;

  ev_t             exp_q[$];
  logic [N_CH-1:0] exp_deb = '0;
  int              checks = 0;
  int              failures = 0;
  int unsigned     t;
  int unsigned     t_press;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input int unsigned ch, input int unsigned kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Advance to the next falling edge and compare all outputs against the scoreboard.
  task automatic tick();
    logic [N_CH-1:0] ep;
    logic [N_CH-1:0] er;
    logic [N_CH-1:0] et;
    ev_t e;
    @(negedge clk);
    ep = '0;
    er = '0;
    et = '0;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc != cyc) chk("missed_event_cycle", e.cyc, cyc);
      else if (e.kind == K_PRESS) ep[e.ch] = 1'b1;
      else if (e.kind == K_REL)   er[e.ch] = 1'b1;
      else                        et[e.ch] = 1'b1;
    end
    if (!reset_n) exp_deb = '0;
    else          exp_deb = (exp_deb | ep) & ~er;
    chk("press",     32'(press),         32'(ep));
    chk("release",   32'(release_pulse), 32'(er));
    chk("repeat",    32'(repeat_pulse),  32'(et));
    chk("debounced", 32'(debounced),     32'(exp_deb));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    noisy   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_debounced", 32'(debounced),     32'h0);
    chk("rst_press",     32'(press),         32'h0);
    chk("rst_release",   32'(release_pulse), 32'h0);
    chk("rst_repeat",    32'(repeat_pulse),  32'h0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Clean press on ch0 held 40 clocks; ch0 has no auto-repeat.
    noisy[0] = 1'b1;
    t = cyc;
    push(t + LAT, 0, K_PRESS);
    repeat (LAT - 1) tick();
    chk("clean_deb_before", 32'(debounced[0]), 32'h0);
    tick();
    chk("clean_deb_after", 32'(debounced[0]), 32'h1);
    repeat (29) tick();

    // Short low glitch while debounced high: no release, no re-press.
    noisy[0] = 1'b0;
    repeat (4) tick();
    noisy[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("glitch_deb_held", 32'(debounced[0]), 32'h1);
    end

    // Clean release of ch0.
    noisy[0] = 1'b0;
    t = cyc;
    push(t + LAT, 0, K_REL);
    repeat (LAT + 2) tick();
    chk("release_deb", 32'(debounced[0]), 32'h0);

    // Bounce: high 5, low 2, high 5, low.
    noisy[0] = 1'b1;
    repeat (5) tick();
    noisy[0] = 1'b0;
    repeat (2) tick();
    noisy[0] = 1'b1;
    repeat (5) tick();
    noisy[0] = 1'b0;
    repeat (20) tick();
    chk("bounce_deb", 32'(debounced[0]), 32'h0);

    // Auto-repeat on ch1 held 60 clocks.
    noisy[1] = 1'b1;
    t = cyc;
    t_press = t + LAT;
    push(t_press, 1, K_PRESS);
    for (int unsigned r = t_press + RD; r <= t + 60 + 2; r += RR) push(r, 1, K_RPT);
    push(t + 60 + LAT, 1, K_REL);
    repeat (60) tick();
    noisy[1] = 1'b0;
    repeat (LAT + 5) tick();
    chk("repeat_deb_low", 32'(debounced[1]), 32'h0);

    // Both channels pressed on the same clock, then reset while ch1 is in REPEAT.
    noisy = 2'b11;
    t = cyc;
    push(t + LAT, 0, K_PRESS);
    push(t + LAT, 1, K_PRESS);
    push(t + LAT + RD, 1, K_RPT);
    repeat (LAT + RD + 2) tick();
    chk("both_deb", 32'(debounced), 32'h3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_debounced", 32'(debounced),     32'h0);
    chk("async_rst_press",     32'(press),         32'h0);
    chk("async_rst_release",   32'(release_pulse), 32'h0);
    chk("async_rst_repeat",    32'(repeat_pulse),  32'h0);
    noisy = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Normal press/release on ch1 after reset, released before repeat delay.
    noisy[1] = 1'b1;
    t = cyc;
    push(t + LAT, 1, K_PRESS);
    push(t + 15 + LAT, 1, K_REL);
    repeat (15) tick();
    noisy[1] = 1'b0;
    repeat (LAT + 3) tick();
    chk("post_rst_deb", 32'(debounced[1]), 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
